// File: rtl/mips_core_pkg.sv
// Shared core widths, instruction-queue sizing and the queue entry layout.
package mips_core_pkg;

  localparam int ADDR_WIDTH            = 32;
  localparam int DATA_WIDTH            = 32;
  localparam int INST_Q_DEPTH_DEFAULT  = 8;
  localparam int INST_Q_PTR_WIDTH      = $clog2(INST_Q_DEPTH_DEFAULT);

  // The word and its PC travel as one record so they can never be separated.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] pc;
  } inst_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Fetch-side, hazard-control and decode-side interfaces of the instruction queue.
interface i_cache_output_ifc;
  import mips_core_pkg::*;

  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic [ADDR_WIDTH-1:0] pc;

  modport in  (input  valid, data, pc);
  modport out (output valid, data, pc);
endinterface

interface hazard_control_ifc;
  logic flush;
  logic stall;

  modport in  (input  flush, stall);
  modport out (output flush, stall);
endinterface

interface inst_q_output_ifc;
  import mips_core_pkg::*;

  logic                  valid;
  logic                  full;
  logic [DATA_WIDTH-1:0] data;
  logic [ADDR_WIDTH-1:0] pc;

  modport in  (input  valid, full, data, pc);
  modport out (output valid, full, data, pc);
endinterface

// File: rtl/inst_queue_ram.sv
// Entry storage: one synchronous write port, one asynchronous read port.
module inst_queue_ram
  import mips_core_pkg::*;
#(
  parameter int DEPTH = INST_Q_DEPTH_DEFAULT,
  parameter int PTR_W = INST_Q_PTR_WIDTH
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  inst_entry_t      wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output inst_entry_t      rdata_o
);

  inst_entry_t mem_q [DEPTH];

  // NOTE: storage has no reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_queue.sv
// Circular instruction FIFO between fetch and decode with first-word fall-through.
module inst_queue
  import mips_core_pkg::*;
#(
  parameter int INST_Q_DEPTH = INST_Q_DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  i_cache_output_ifc.in i_cache_output,
  hazard_control_ifc.in hc,
  inst_q_output_ifc.out out
);

  localparam int PTR_W = $clog2(INST_Q_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(INST_Q_DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             q_valid, q_full, push, pop;
  inst_entry_t      wr_entry, rd_entry;

  assign q_valid = (count_q != '0);
  assign q_full  = (count_q == FULL_COUNT);

  // A full queue refuses input even when a pop frees a slot this cycle.
  assign push = i_cache_output.valid && !q_full && !hc.flush;
  assign pop  = q_valid && !hc.stall && !hc.flush;

  // NOTE: every next-state signal takes its hold value first so no latch is inferred.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (hc.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign wr_entry.data = i_cache_output.data;
  assign wr_entry.pc   = i_cache_output.pc;

  inst_queue_ram #(
    .DEPTH (INST_Q_DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (push && !rst),
    .waddr_i (tail_q),
    .wdata_i (wr_entry),
    .raddr_i (head_q),
    .rdata_o (rd_entry)
  );

  assign out.valid = q_valid;
  assign out.full  = q_full;
  assign out.data  = rd_entry.data;
  assign out.pc    = rd_entry.pc;

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: directed pushes queue expectations, a monitor checks decode output.
module tb_inst_queue;
  import mips_core_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i_cache_output_ifc ic();
  hazard_control_ifc hc_if();
  inst_q_output_ifc  oq();

  inst_queue #(.INST_Q_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_cache_output (ic),
    .hc             (hc_if),
    .out            (oq)
  );

  int          checks = 0;
  int          errors = 0;
  int          m_count = 0;
  bit          mon_en = 1'b0;
  inst_entry_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock edge and track the expected occupancy from the applied inputs.
  task automatic step();
    int p, q;
    @(posedge clk);
    if (rst || hc_if.flush) m_count = 0;
    else begin
      p = (ic.valid && m_count != DEPTH) ? 1 : 0;
      q = (m_count != 0 && !hc_if.stall) ? 1 : 0;
      m_count = m_count + p - q;
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] pc,
                       input logic st, input logic fl, input logic r, input bit acc);
    inst_entry_t e;
    ic.valid    = v;
    ic.data     = d;
    ic.pc       = pc;
    hc_if.stall = st;
    hc_if.flush = fl;
    rst         = r;
    if (fl || r) sb.delete();
    if (acc) begin
      e.data = d;
      e.pc   = pc;
      sb.push_back(e);
    end
    step();
  endtask

  task automatic idle(input int n, input logic st);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, st, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: status every cycle, and the head entry whenever decode takes it.
  always @(negedge clk) begin
    inst_entry_t e;
    if (mon_en && !rst) begin
      check("valid", 64'(oq.valid), 64'(m_count != 0));
      check("full",  64'(oq.full),  64'(m_count == DEPTH));
      if (oq.valid && !hc_if.stall && !hc_if.flush) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got pc 0x%0h expected no output", oq.pc);
        end else begin
          e = sb.pop_front();
          check("data", 64'(oq.data), 64'(e.data));
          check("pc",   64'(oq.pc),   64'(e.pc));
        end
      end
    end
  end

  initial begin
    ic.valid    = 1'b0;
    ic.data     = '0;
    ic.pc       = '0;
    hc_if.stall = 1'b0;
    hc_if.flush = 1'b0;

    // Reset then idle
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    mon_en = 1'b1;
    check("reset_valid", 64'(oq.valid), 64'(0));
    check("reset_full",  64'(oq.full),  64'(0));
    idle(3, 1'b0);

    // Single pass-through
    drive(1'b1, 32'h2008000A, 32'h0040, 1'b0, 1'b0, 1'b0, 1'b1);
    check("pass_valid", 64'(oq.valid), 64'(1));
    check("pass_data",  64'(oq.data),  64'h2008000A);
    check("pass_pc",    64'(oq.pc),    64'h0040);
    idle(1, 1'b0);
    check("pass_drained", 64'(oq.valid), 64'(0));
    idle(2, 1'b0);

    // Fill under stall; ninth word dropped
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 32'h1000 + 32'(i), 32'(i * 4), 1'b1, 1'b0, 1'b0, i < 8);
      if (i == 7) check("full_after_8", 64'(oq.full), 64'(1));
    end
    check("full_after_9", 64'(oq.full), 64'(1));
    idle(10, 1'b0);
    check("fill_drained", 64'(oq.valid), 64'(0));

    // Streaming with concurrent push/pop, pointers wrap twice
    for (int i = 0; i < 20; i++)
      drive(1'b1, 32'hA000 + 32'(i), 32'h300 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b0);

    // Flush dominates stall and same-cycle input
    for (int i = 0; i < 5; i++)
      drive(1'b1, 32'hB000 + 32'(i), 32'h80 + 32'(i * 4), 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'hDEAD0100, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0);
    check("flush_valid", 64'(oq.valid), 64'(0));
    idle(4, 1'b0);

    // Reset mid-operation, then a fresh push is the first output
    for (int i = 0; i < 3; i++)
      drive(1'b1, 32'hC000 + 32'(i), 32'h180 + 32'(i * 4), 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'hDEAD0999, 32'h999, 1'b0, 1'b0, 1'b1, 1'b0);
    check("rst_mid_valid", 64'(oq.valid), 64'(0));
    drive(1'b1, 32'h20000200, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1);
    check("post_rst_pc", 64'(oq.pc), 64'h200);
    idle(4, 1'b0);

    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
